// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline constants for the fetch stage, also used by decode and exception logic.
// Holds the default reset/exception vectors, the bubble encoding and the PC increment rule.
package instruction_fetch_pkg;

    localparam logic [31:0] DefaultResetPc   = 32'h0000_0000;
    localparam logic [31:0] DefaultExcVector = 32'h8000_0008;
    localparam logic [31:0] DefaultNopInstr  = 32'h0000_0000;

    // PC[31] is the kernel bit: only the low 31 bits wrap on increment.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        logic [30:0] low;
        low = pc[30:0] + 31'd4;
        return {pc[31], low};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for the fetch stage, with misaligned-redirect detection.
module pc_next_sel
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DefaultExcVector
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_valid,
    output logic [31:0] pc_next,
    output logic        misalign_next
);

    logic target_misaligned;

    assign target_misaligned = (redirect_target[1:0] != 2'b00);

    always_comb begin
        pc_next       = pc_incr(pc);
        misalign_next = 1'b0;
        if (exc_valid) begin
            pc_next = EXC_VECTOR;
        end else if (redirect_valid && target_misaligned) begin
            pc_next       = EXC_VECTOR;
            misalign_next = 1'b1;
        end else if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (stall) begin
            pc_next = pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational ROM address and the IF/ID pipeline
// register, with stall/flush/redirect/exception handling.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DefaultResetPc,
    parameter logic [31:0] EXC_VECTOR = DefaultExcVector,
    parameter logic [31:0] NOP_INSTR  = DefaultNopInstr
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_d;
    logic        bubble;

    pc_next_sel #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_pc_next_sel (
        .pc              (pc_q),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .pc_next         (pc_d),
        .misalign_next   (misalign_d)
    );

    assign rom_addr = pc_q;
    // Anything that changes control flow kills the word currently being fetched.
    assign bubble   = flush || exc_valid || redirect_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            misalign <= misalign_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'h0000_0000;
            ifid_valid    <= 1'b0;
        end else if (bubble) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= pc_incr(pc_q);
            ifid_valid    <= 1'b0;
        end else if (!stall) begin
            ifid_instr    <= rom_data;
            ifid_pc_plus4 <= pc_incr(pc_q);
            ifid_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a scoreboard of expected IF/ID state.
module tb_instruction_fetch;

    localparam logic [31:0] ExcVec = 32'h8000_0008;
    localparam logic [31:0] Nop    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misalign;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] p4;
        logic [31:0] pc;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Bench-side model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_p4;
    logic        m_valid;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid),
        .misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign rom_data = rom_word(rom_addr);

    function automatic logic [31:0] model_inc(input logic [31:0] pc);
        logic [31:0] sum;
        sum = pc + 32'd4;
        return (sum & 32'h7FFF_FFFF) | (pc & 32'h8000_0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the result, advance one edge and compare.
    task automatic step(input logic st, input logic fl, input logic rv,
                        input logic [31:0] rt, input logic ex, input string tag);
        exp_t e;
        check({tag, ":rom_addr_pre"}, rom_addr, m_pc);
        stall = st; flush = fl; redirect_valid = rv; redirect_target = rt; exc_valid = ex;
        if (fl || ex || rv) begin
            m_instr = Nop; m_valid = 1'b0; m_p4 = model_inc(m_pc);
        end else if (!st) begin
            m_instr = rom_word(m_pc); m_valid = 1'b1; m_p4 = model_inc(m_pc);
        end
        if (ex)                       e.pc = ExcVec;
        else if (rv && rt[1:0] != 0)  e.pc = ExcVec;
        else if (rv)                  e.pc = rt;
        else if (st)                  e.pc = m_pc;
        else                          e.pc = model_inc(m_pc);
        e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid;
        e.mis   = !ex && rv && (rt[1:0] != 2'b00);
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0; exc_valid = 0;
        e = sb.pop_front();
        m_pc = e.pc;
        check({tag, ":ifid_instr"}, ifid_instr, e.instr);
        check({tag, ":ifid_pc_plus4"}, ifid_pc_plus4, e.p4);
        check({tag, ":ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
        check({tag, ":misalign"}, {31'd0, misalign}, {31'd0, e.mis});
        check({tag, ":rom_addr"}, rom_addr, e.pc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":rom_addr"}, rom_addr, 32'h0);
        check({tag, ":ifid_instr"}, ifid_instr, Nop);
        check({tag, ":ifid_pc_plus4"}, ifid_pc_plus4, 32'h0);
        check({tag, ":ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, ":misalign"}, {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
        exc_valid = 0;
        m_pc = 32'h0; m_instr = Nop; m_p4 = 32'h0; m_valid = 1'b0;
        #2;
        check_reset_state("reset");
        #10 reset = 1'b1;   // released mid-cycle, before the edge at t=15

        // Reset release: fetch 0x0, 0x4, 0x8
        step(0, 0, 0, 32'h0, 0, "run0");
        check("first_instr", ifid_instr, 32'h2008_0005);
        step(0, 0, 0, 32'h0, 0, "run1");
        // Stall 3 cycles at PC=0x8
        step(1, 0, 0, 32'h0, 0, "stall0");
        step(1, 0, 0, 32'h0, 0, "stall1");
        step(1, 0, 0, 32'h0, 0, "stall2");
        step(0, 0, 0, 32'h0, 0, "unstall");
        check("pc_after_stall", rom_addr, 32'h0000_000C);
        step(0, 0, 0, 32'h0, 0, "to_0x10");
        // Redirect overriding stall
        step(1, 0, 1, 32'h0000_0040, 0, "redir_stall");
        step(0, 0, 0, 32'h0, 0, "fetch_0x40");
        // Misaligned redirect: one-cycle pulse
        step(0, 0, 1, 32'h0000_0042, 0, "misaligned");
        step(0, 0, 0, 32'h0, 0, "mis_clear");
        // Exception beats redirect, no misalign
        step(0, 0, 1, 32'h0000_0042, 1, "exc_redir");
        // Flush alone keeps PC flow; stall+flush gives bubble with PC held
        step(0, 1, 0, 32'h0, 0, "flush");
        step(1, 1, 0, 32'h0, 0, "stall_flush");
        // Back-to-back redirects
        step(0, 0, 1, 32'h0000_0100, 0, "b2b0");
        step(0, 0, 1, 32'h0000_0200, 0, "b2b1");
        step(0, 0, 0, 32'h0, 0, "b2b_fetch");
        // User-space wrap and kernel-bit preservation
        step(0, 0, 1, 32'h7FFF_FFFC, 0, "to_wrap");
        step(0, 0, 0, 32'h0, 0, "wrap");
        check("wrap_pc_plus4", ifid_pc_plus4, 32'h0000_0000);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, "to_kwrap");
        step(0, 0, 0, 32'h0, 0, "kwrap");
        check("kwrap_pc", rom_addr, 32'h8000_0000);
        step(0, 0, 0, 32'h0, 0, "post_kwrap");

        // Reset mid-stream with a pending misaligned redirect
        redirect_valid = 1'b1; redirect_target = 32'h0000_0042;
        #2 reset = 1'b0;
        #1 check_reset_state("async_reset");
        @(posedge clk);
        #1 check_reset_state("reset_held");
        redirect_valid = 1'b0; redirect_target = 32'h0;
        #3 reset = 1'b1;
        m_pc = 32'h0; m_instr = Nop; m_p4 = 32'h0; m_valid = 1'b0;
        step(0, 0, 0, 32'h0, 0, "rerun0");
        check("rerun_instr", ifid_instr, 32'h2008_0005);
        step(0, 0, 0, 32'h0, 0, "rerun1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have the parameters below (one per line: name, default, meaning).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0008, PC loaded on exception or misaligned redirect.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

REQ-002 The block SHALL have the ports below (one per line: name, direction, width, meaning).
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- rom_addr, out, 32, byte address to the instruction ROM; equals PC.
- rom_data, in, 32, instruction word returned combinationally by the ROM.
- stall, in, 1, hold PC and IF/ID contents.
- flush, in, 1, replace the next IF/ID contents with a bubble.
- redirect_valid, in, 1, branch/jump taken this cycle.
- redirect_target, in, 32, byte target of the branch/jump.
- exc_valid, in, 1, exception/interrupt request this cycle.
- ifid_instr, out, 32, registered instruction to decode.
- ifid_pc_plus4, out, 32, registered PC+4 of ifid_instr.
- ifid_valid, out, 1, ifid_instr is a real fetched instruction.
- misalign, out, 1, registered one-cycle pulse on a misaligned redirect.

Function
REQ-003 rom_addr SHALL be combinationally equal to the PC register, so an instruction is fetched with zero added latency.
REQ-004 Incrementing the PC SHALL add 4 to PC[30:0] modulo 2^31 while preserving PC[31] (kernel bit). Examples: 0x7FFF_FFFC -> 0x0000_0000; 0xFFFF_FFFC -> 0x8000_0000.
REQ-005 The next PC SHALL be chosen by this strict priority:
- exc_valid -> EXC_VECTOR.
- redirect_valid with redirect_target[1:0] != 0 -> EXC_VECTOR.
- redirect_valid with an aligned target -> redirect_target.
- stall -> hold the current PC.
- otherwise -> incremented PC.
REQ-006 exc_valid and redirect_valid SHALL override stall: the PC updates even while stall=1.
REQ-007 The IF/ID register update SHALL follow this priority:
- bubble when flush, exc_valid or redirect_valid is asserted: ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc_plus4 = incremented current PC.
- otherwise, hold when stall=1.
- otherwise, load rom_data, incremented PC and valid=1.
REQ-008 Simultaneous stall and flush SHALL produce a bubble; flush SHALL NOT by itself alter the PC.
REQ-009 misalign SHALL be 1 for exactly the cycle after a misaligned redirect is accepted with exc_valid=0, and 0 otherwise.
REQ-010 Back-to-back redirects on consecutive cycles SHALL each be honoured in turn, each producing a bubble.

Reset
REQ-011 While reset=0, the block SHALL asynchronously force:
- PC=RESET_PC, so rom_addr=RESET_PC.
- ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, misalign=0.
REQ-012 On the first rising edge after reset deasserts (with no stall), the block SHALL load the instruction at RESET_PC with ifid_valid=1.
REQ-013 Reset asserted mid-operation SHALL discard any pending redirect or exception, with no residual misalign pulse.

Structure
REQ-014 RESET_PC, EXC_VECTOR, NOP_INSTR and the PC-increment width rule SHALL live in the shared pipeline constants package, for reuse by the decode and exception logic.
REQ-015 The block SHALL contain one sub-module, pc_next_sel (the combinational priority mux of REQ-005, including the misalign detect). The PC register and IF/ID register SHALL stay in instruction_fetch.

Verification
REQ-016 The bench SHALL cover at least the following directed scenarios (stimulus -> required response):
- Reset release with ROM[0]=0x2008_0005, no stall: rom_addr sequence 0x0, 0x4, 0x8; after the first edge, ifid_instr=0x2008_0005, ifid_pc_plus4=0x4, ifid_valid=1.
- stall=1 for 3 cycles at PC=0x8: rom_addr stays 0x8 and ifid_* hold; on release, the PC advances to 0xC.
- redirect_valid=1 to 0x0000_0040 at PC=0x10, concurrent with stall=1: next PC=0x40, IF/ID bubble (ifid_valid=0); the next cycle fetches 0x40.
- redirect_target=0x0000_0042: next PC=0x8000_0008 and misalign pulses for exactly one cycle.
- exc_valid=1 and redirect_valid=1 together: PC=0x8000_0008, misalign=0, bubble.
- PC=0x7FFF_FFFC with no stall: next PC=0x0000_0000 and ifid_pc_plus4=0x0000_0000.
- reset asserted mid-stream: outputs take their reset values immediately, without waiting for a clock edge.
